// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and index constants for the pipeline hazard controller.
// Stage indices name the pipeline registers the controller gates.
package pipe_hazard_ctrl_pkg;

    localparam int FWD_RF   = 0;
    localparam int ST_IF_ID = 0;
    localparam int ST_ID_EX = 1;

    typedef struct packed {
        logic vld;
        logic wr;
        logic ld;
    } sb_flags_t;

    typedef enum logic [1:0] {
        MODE_NORMAL,
        MODE_HAZARD,
        MODE_REDIRECT,
        MODE_WAIT
    } ctl_mode_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake bundle between the pipeline datapath (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int R      = 4,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 16
);
    logic              id_vld;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use1;
    logic              id_use2;
    logic [REG_AW-1:0] id_rd;
    logic              id_wr;
    logic              id_ld;
    logic              ex_redirect;
    logic              dmem_wait;
    logic              perf_clr;
    logic              pc_en;
    logic [R-1:0]      st_en;
    logic [R-1:0]      st_flush;
    logic [SEL_W-1:0]  fwd1_sel;
    logic [SEL_W-1:0]  fwd2_sel;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_vld, id_rs1, id_rs2, id_use1, id_use2, id_rd, id_wr, id_ld,
               ex_redirect, dmem_wait, perf_clr,
        input  pc_en, st_en, st_flush, fwd1_sel, fwd2_sel, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_vld, id_rs1, id_rs2, id_use1, id_use2, id_rd, id_wr, id_ld,
               ex_redirect, dmem_wait, perf_clr,
        output pc_en, st_en, st_flush, fwd1_sel, fwd2_sel, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_scoreboard.sv
// Shift-register scoreboard of in-flight writers; entry 0 is EX, entry D-1 is WB.
// Shifts only when the ID/EX register is enabled; a bubble clears all fields.
module pipe_hazard_ctrl_scoreboard
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int D      = 3,
    parameter int REG_AW = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                adv,
    input  logic                in_vld,
    input  logic [REG_AW-1:0]   in_rd,
    input  logic                in_wr,
    input  logic                in_ld,
    output logic [D-1:0]        ent_vld,
    output logic [D-1:0]        ent_wr,
    output logic [D-1:0]        ent_ld,
    output logic [D*REG_AW-1:0] ent_rd
);

    sb_flags_t         flags_reg [D];
    logic [REG_AW-1:0] rd_reg    [D];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < D; i++) begin
                flags_reg[i] <= '0;
                rd_reg[i]    <= '0;
            end
        end else if (adv) begin
            flags_reg[0] <= '{vld: in_vld, wr: in_vld && in_wr, ld: in_vld && in_ld};
            rd_reg[0]    <= in_vld ? in_rd : '0;
            for (int i = 1; i < D; i++) begin
                flags_reg[i] <= flags_reg[i-1];
                rd_reg[i]    <= rd_reg[i-1];
            end
        end
    end

    for (genvar gi = 0; gi < D; gi++) begin : g_flat
        assign ent_vld[gi]                    = flags_reg[gi].vld;
        assign ent_wr[gi]                     = flags_reg[gi].wr;
        assign ent_ld[gi]                     = flags_reg[gi].ld;
        assign ent_rd[gi*REG_AW +: REG_AW]    = rd_reg[gi];
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall/forward controller for an in-order pipeline of NUM_STAGES stages.
// Outputs are combinational from scoreboard state and current inputs.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int NUM_STAGES = 5,
    parameter int REG_AW     = 5,
    parameter int LOAD_LAT   = 0,
    parameter int FWD_EN     = 1,
    parameter int CNT_W      = 16
) (
    input logic               clk,
    input logic               rst_n,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int D     = NUM_STAGES - 2;
    localparam int SEL_W = $clog2(D);

    logic [D-1:0]        ent_vld, ent_wr, ent_ld;
    logic [D*REG_AW-1:0] ent_rd;
    logic                adv, sb_in_vld, hazard;
    logic [REG_AW-1:0]   ex_rs1_reg, ex_rs2_reg;
    logic                ex_use1_reg, ex_use2_reg;
    logic [D-1:0]        id1_m, id2_m, haz_win;
    logic [D-1:1]        ex1_ok, ex2_ok;
    logic [CNT_W-1:0]    stall_cnt_reg, flush_cnt_reg;
    ctl_mode_t           mode;

    pipe_hazard_ctrl_scoreboard #(.D(D), .REG_AW(REG_AW)) u_sb (
        .clk    (clk),
        .rst_n  (rst_n),
        .adv    (adv),
        .in_vld (sb_in_vld),
        .in_rd  (bus.id_rd),
        .in_wr  (bus.id_wr),
        .in_ld  (bus.id_ld),
        .ent_vld(ent_vld),
        .ent_wr (ent_wr),
        .ent_ld (ent_ld),
        .ent_rd (ent_rd)
    );

    for (genvar gi = 0; gi < D; gi++) begin : g_match
        logic [REG_AW-1:0] rd;
        logic              wr_live;
        assign rd        = ent_rd[gi*REG_AW +: REG_AW];
        assign wr_live   = ent_vld[gi] && ent_wr[gi] && (rd != '0);
        assign id1_m[gi] = bus.id_use1 && wr_live && (rd == bus.id_rs1);
        assign id2_m[gi] = bus.id_use2 && wr_live && (rd == bus.id_rs2);

        // A load within EX..EX+LOAD_LAT cannot supply data by the time its consumer reaches EX.
        if (FWD_EN != 0) begin : g_win_fwd
            assign haz_win[gi] = (gi <= LOAD_LAT) && ent_ld[gi];
        end else begin : g_win_nofwd
            assign haz_win[gi] = (gi <= D - 2);
        end

        if (gi >= 1) begin : g_ex
            logic fwdable;
            assign fwdable    = !ent_ld[gi] || (gi + 1 >= 2 + LOAD_LAT);
            assign ex1_ok[gi] = ex_use1_reg && wr_live && (rd == ex_rs1_reg) && fwdable;
            assign ex2_ok[gi] = ex_use2_reg && wr_live && (rd == ex_rs2_reg) && fwdable;
        end
    end

    assign hazard = bus.id_vld && |((id1_m | id2_m) & haz_win);

    always_comb begin
        mode = MODE_NORMAL;
        if (!rst_n)                mode = MODE_NORMAL;
        else if (bus.dmem_wait)    mode = MODE_WAIT;
        else if (bus.ex_redirect)  mode = MODE_REDIRECT;
        else if (hazard)           mode = MODE_HAZARD;
    end

    always_comb begin
        bus.pc_en    = 1'b1;
        bus.st_en    = '1;
        bus.st_flush = '0;
        unique case (mode)
            MODE_WAIT: begin
                bus.pc_en = 1'b0;
                bus.st_en = '0;
            end
            MODE_REDIRECT: begin
                bus.st_flush[ST_IF_ID] = 1'b1;
                bus.st_flush[ST_ID_EX] = 1'b1;
            end
            MODE_HAZARD: begin
                bus.pc_en              = 1'b0;
                bus.st_en[ST_IF_ID]    = 1'b0;
                bus.st_flush[ST_ID_EX] = 1'b1;
            end
            default: ;
        endcase
    end

    // Scan from the oldest entry down so the youngest matching producer wins.
    always_comb begin
        bus.fwd1_sel = SEL_W'(FWD_RF);
        bus.fwd2_sel = SEL_W'(FWD_RF);
        if (FWD_EN != 0) begin
            for (int i = D - 1; i >= 1; i--) begin
                if (ex1_ok[i]) bus.fwd1_sel = SEL_W'(i);
                if (ex2_ok[i]) bus.fwd2_sel = SEL_W'(i);
            end
        end
    end

    assign adv       = bus.st_en[ST_ID_EX];
    assign sb_in_vld = bus.id_vld && !bus.st_flush[ST_ID_EX];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rs1_reg  <= '0;
            ex_rs2_reg  <= '0;
            ex_use1_reg <= 1'b0;
            ex_use2_reg <= 1'b0;
        end else if (adv) begin
            ex_rs1_reg  <= bus.id_rs1;
            ex_rs2_reg  <= bus.id_rs2;
            ex_use1_reg <= sb_in_vld && bus.id_use1;
            ex_use2_reg <= sb_in_vld && bus.id_use2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else if (bus.perf_clr) begin
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            if (mode == MODE_HAZARD && stall_cnt_reg != '1)
                stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
            if (mode == MODE_REDIRECT && flush_cnt_reg != '1)
                flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
        end
    end

    assign bus.stall_cnt = stall_cnt_reg;
    assign bus.flush_cnt = flush_cnt_reg;

endmodule
